// File: rtl/mont_mul_arbiter_pkg.sv
// Shared definitions for the montgomery multiplier arbiter: FSM encoding,
// default sizes and the round-robin pointer advance helper.
package mont_mul_arbiter_pkg;

  localparam int WIDTH_DEF = 1024;
  localparam int NREQ_DEF  = 4;
  localparam int IDXW      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Requester index after idx, wrapping nreq-1 back to 0.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx,
                                               input int unsigned     nreq);
    logic [IDXW-1:0] nxt;
    if (32'(idx) == nreq - 1) nxt = '0;
    else                      nxt = idx + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/mont_mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: level requests with packed
// operands, one-hot grant/done pulses, shared result and busy flag.
interface mont_mul_arbiter_if
  import mont_mul_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  busy;

  modport master (
    output req, req_a, req_b,
    input  gnt, done, result, busy
  );

  modport slave (
    input  req, req_a, req_b,
    output gnt, done, result, busy
  );

endinterface

// File: rtl/mont_mul_arbiter_rr_pick.sv
// Combinational round-robin winner: first set request scanning from ptr_i
// upwards modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            any_o,
  output logic [IDXW-1:0] idx_o
);

  logic [IDXW-1:0] cand;

  // Scan candidates in priority order, keep the first requesting one.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDXW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one montgomery multiplier between NREQ requesters. Round-robin
// arbitration, registered operand capture, multiplier resetn/start/done
// sequencing and a one-hot done pulse with the product.
module mont_mul_arbiter
  import mont_mul_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mont_mul_arbiter_if.slave bus_if,
  output logic             mult_resetn_o,
  output logic             mult_start_o,
  output logic [WIDTH-1:0] mult_a_o,
  output logic [WIDTH-1:0] mult_b_o,
  input  logic [WIDTH-1:0] mult_result_i,
  input  logic             mult_done_i
);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  cur_idx_q, cur_idx_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             sticky_q, sticky_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             resetn_q, resetn_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             pick_any;
  logic [IDXW-1:0]  pick_idx;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i (bus_if.req),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Next-state logic; pulse outputs are computed one state early so that
  // gnt/start appear in LAUNCH and done appears as the FSM returns to IDLE,
  // all straight from flops.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    rr_ptr_d  = rr_ptr_q;
    sticky_d  = sticky_q;
    result_d  = result_q;
    a_d       = a_q;
    b_d       = b_q;
    gnt_d     = '0;
    done_d    = '0;
    start_d   = 1'b0;
    resetn_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          cur_idx_d       = pick_idx;
          a_d             = bus_if.req_a[32'(pick_idx)*WIDTH +: WIDTH];
          b_d             = bus_if.req_b[32'(pick_idx)*WIDTH +: WIDTH];
          gnt_d[pick_idx] = 1'b1;
          start_d         = 1'b1;
          resetn_d        = 1'b1;
          state_d         = LAUNCH;
        end
      end
      LAUNCH: begin
        sticky_d = 1'b0;
        resetn_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        resetn_d = 1'b1;
        sticky_d = sticky_q | mult_done_i;
        if (sticky_d) state_d = RESP;
      end
      RESP: begin
        result_d          = mult_result_i;
        done_d[cur_idx_q] = 1'b1;
        rr_ptr_d          = next_idx(cur_idx_q, NREQ);
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_idx_q <= '0;
      rr_ptr_q  <= '0;
      sticky_q  <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      resetn_q  <= 1'b0;
      start_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      sticky_q  <= sticky_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      result_q  <= result_d;
      resetn_q  <= resetn_d;
      start_q   <= start_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign bus_if.gnt    = gnt_q;
  assign bus_if.done   = done_q;
  assign bus_if.result = result_q;
  assign bus_if.busy   = (state_q != IDLE);
  assign mult_resetn_o = resetn_q;
  assign mult_start_o  = start_q;
  assign mult_a_o      = a_q;
  assign mult_b_o      = b_q;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter with an XOR stub multiplier whose done
// rises 5 cycles after it samples start (pulse or 4-cycle level).
module tb_mont_mul_arbiter;

  localparam int WIDTH = 1024;
  localparam int NREQ  = 4;

  logic             clk;
  logic             reset;
  logic             mult_resetn;
  logic             mult_start;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic [WIDTH-1:0] mult_result;
  logic             mult_done;
  logic             level_mode;
  int unsigned      scnt;

  int unsigned nvec;
  int unsigned nerr;

  mont_mul_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  mont_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_if        (bus),
    .mult_resetn_o (mult_resetn),
    .mult_start_o  (mult_start),
    .mult_a_o      (mult_a),
    .mult_b_o      (mult_b),
    .mult_result_i (mult_result),
    .mult_done_i   (mult_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub multiplier: XOR product; done follows start by 5 cycles.
  assign mult_result = mult_a ^ mult_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt      <= 0;
      mult_done <= 1'b0;
    end else begin
      if (mult_start)                scnt <= 1;
      else if (scnt != 0 && scnt < 20) scnt <= scnt + 1;
      mult_done <= level_mode ? (scnt >= 5 && scnt <= 8) : (scnt == 5);
    end
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Runs one transaction from a negedge with req already driven: drops the
  // granted request, then checks grant/done pulses, latency and product.
  task automatic serve(input string tag, input logic [NREQ-1:0] exp_oh,
                       input logic [WIDTH-1:0] exp_res);
    int unsigned     gcyc, dcyc, gcnt;
    logic [NREQ-1:0] gval, dval;
    logic            st_g, rn_g, busy_g, busy_d, rn_d;
    logic [WIDTH-1:0] res_d;
    gcyc = 0; dcyc = 0; gcnt = 0; gval = '0; dval = '0;
    st_g = 1'b0; rn_g = 1'b0; busy_g = 1'b0; busy_d = 1'b1; rn_d = 1'b1; res_d = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        gcnt++;
        if (gcyc == 0) begin
          gcyc   = k;
          gval   = bus.gnt;
          st_g   = mult_start;
          rn_g   = mult_resetn;
          busy_g = bus.busy;
          bus.req = bus.req & ~bus.gnt;
        end
      end
      if (bus.done != '0) begin
        dcyc   = k;
        dval   = bus.done;
        busy_d = bus.busy;
        rn_d   = mult_resetn;
        res_d  = bus.result;
        break;
      end
    end
    chk({tag, " gnt"},        WIDTH'(gval),   WIDTH'(exp_oh));
    chk({tag, " gnt_cycle"},  WIDTH'(gcyc),   1);
    chk({tag, " gnt_count"},  WIDTH'(gcnt),   1);
    chk({tag, " start"},      WIDTH'(st_g),   1);
    chk({tag, " resetn_run"}, WIDTH'(rn_g),   1);
    chk({tag, " busy_run"},   WIDTH'(busy_g), 1);
    chk({tag, " done"},       WIDTH'(dval),   WIDTH'(exp_oh));
    chk({tag, " done_cycle"}, WIDTH'(dcyc),   9);
    chk({tag, " result"},     res_d,          exp_res);
    chk({tag, " busy_idle"},  WIDTH'(busy_d), 0);
    chk({tag, " resetn_idle"},WIDTH'(rn_d),   0);
  endtask

  logic [NREQ-1:0]  ord_oh  [6];
  logic [WIDTH-1:0] ord_res [6];
  logic [NREQ-1:0]  seen;

  initial begin
    nvec = 0; nerr = 0;
    level_mode = 1'b0;
    // Operand table; products: r0=1E r1=D2 r2=6 r3=48
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[0*WIDTH +: WIDTH] = WIDTH'('h11); bus.req_b[0*WIDTH +: WIDTH] = WIDTH'('h0F);
    bus.req_a[1*WIDTH +: WIDTH] = WIDTH'('h22); bus.req_b[1*WIDTH +: WIDTH] = WIDTH'('hF0);
    bus.req_a[2*WIDTH +: WIDTH] = WIDTH'('h05); bus.req_b[2*WIDTH +: WIDTH] = WIDTH'('h03);
    bus.req_a[3*WIDTH +: WIDTH] = WIDTH'('h44); bus.req_b[3*WIDTH +: WIDTH] = WIDTH'('h0C);

    // 1. reset held 3 cycles with all requests high
    reset   = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst gnt",    WIDTH'(bus.gnt),     0);
      chk("rst done",   WIDTH'(bus.done),    0);
      chk("rst resetn", WIDTH'(mult_resetn), 0);
      chk("rst busy",   WIDTH'(bus.busy),    0);
    end
    chk("rst result", bus.result, 0);
    chk("rst mult_a", mult_a,     0);
    chk("rst start",  WIDTH'(mult_start), 0);
    bus.req = '0;
    reset   = 1'b0;
    @(negedge clk);

    // 3. requesters 0,1,3 keep requesting -> 0,1,3,0,1,3
    ord_oh  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    ord_res = '{WIDTH'('h1E), WIDTH'('hD2), WIDTH'('h48),
                WIDTH'('h1E), WIDTH'('hD2), WIDTH'('h48)};
    for (int t = 0; t < 6; t++) begin
      bus.req = 4'b1011;
      serve($sformatf("rr%0d", t), ord_oh[t], ord_res[t]);
    end
    bus.req = '0;
    @(negedge clk);

    // 2. single requester 2, a=5 b=3
    bus.req = 4'b0100;
    serve("single2", 4'b0100, WIDTH'('h6));

    // 4. pointer now 3: requester 3 before requester 0
    bus.req = 4'b1001;
    serve("ptr3_first", 4'b1000, WIDTH'('h48));
    serve("ptr3_then0", 4'b0001, WIDTH'('h1E));

    // 5. reset two cycles into WAIT aborts without a done
    bus.req = 4'b0010;
    @(negedge clk);
    chk("abort gnt", WIDTH'(bus.gnt), WIDTH'(4'b0010));
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy",   WIDTH'(bus.busy),    0);
    chk("abort resetn", WIDTH'(mult_resetn), 0);
    chk("abort done",   WIDTH'(bus.done),    0);
    reset = 1'b0;
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen = seen | bus.done | bus.gnt;
    end
    chk("abort quiet", WIDTH'(seen), 0);
    bus.req = 4'b0010;
    serve("after_abort", 4'b0010, WIDTH'('hD2));

    // 6. level done held 4 cycles, immediate next request
    level_mode = 1'b1;
    bus.req = 4'b1000;
    serve("level3", 4'b1000, WIDTH'('h48));
    bus.req = 4'b0001;
    serve("level_next0", 4'b0001, WIDTH'('h1E));
    level_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
